// File: rtl/group_fifo_drain.sv
// Drains a banked group FIFO into a small skid buffer under credit control.
// One pop request can be outstanding; responses land one cycle after acceptance.
module group_fifo_drain #(
    parameter int GID_WIDTH = 16,
    parameter int BUF_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 drain_en,
    input  logic                 fifo_peek_valid,
    output logic                 fifo_pop_ready,
    input  logic                 fifo_pop_valid,
    input  logic [GID_WIDTH-1:0] fifo_pop_gid,
    output logic                 out_valid,
    output logic [GID_WIDTH-1:0] out_gid,
    input  logic                 out_ready,
    output logic                 idle,
    output logic [31:0]          groups_out,
    output logic                 spurious_err,
    output logic                 drop_err
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(BUF_DEPTH);
    localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(BUF_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } state_t;

    state_t               state_q, state_d;
    logic                 inflight_q, inflight_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [31:0]          groups_q, groups_d;
    logic                 spurious_q, spurious_d;
    logic                 drop_q, drop_d;
    logic [GID_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [GID_WIDTH-1:0] mem_d [BUF_DEPTH];

    logic [CNT_W:0] credit;
    logic           full;
    logic           hs;
    logic           wr;

    // Credit counts the in-flight response but not a same-cycle handshake.
    assign credit = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q};
    assign full   = (count_q == FULL_C);

    assign fifo_pop_ready = !rst && (state_q == RUN) && drain_en &&
                            fifo_peek_valid && (credit < DEPTH_C);
    assign out_valid      = !rst && (count_q != '0);
    assign out_gid        = mem_q[rd_ptr_q];
    assign hs             = out_valid && out_ready;
    assign wr             = fifo_pop_valid && (!full || hs);

    assign idle         = (state_q == IDLE) && (count_q == '0) && !inflight_q;
    assign groups_out   = groups_q;
    assign spurious_err = spurious_q;
    assign drop_err     = drop_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (drain_en) state_d = RUN;
            end
            RUN: begin
                if (!drain_en) state_d = STOPPING;
            end
            STOPPING: begin
                if (drain_en)         state_d = RUN;
                else if (!inflight_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        inflight_d = fifo_pop_ready;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        groups_d   = groups_q;
        spurious_d = spurious_q;
        drop_d     = drop_q;
        mem_d      = mem_q;

        if (wr) begin
            mem_d[wr_ptr_q] = fifo_pop_gid;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (hs) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            groups_d = groups_q + 32'd1;
        end

        unique case ({wr, hs})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (fifo_pop_valid && !inflight_q) spurious_d = 1'b1;
        if (fifo_pop_valid && !wr)         drop_d     = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            groups_q   <= '0;
            spurious_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            groups_q   <= groups_d;
            spurious_q <= spurious_d;
            drop_q     <= drop_d;
        end
    end

    // Buffer storage needs no reset; out_valid masks stale entries.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: tb/tb_group_fifo_drain.sv
// Directed bench for group_fifo_drain: a cycle table for the basic drain
// plus hand sequences around credit, full-buffer and error corners.
module tb_group_fifo_drain;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        drain_en = 1'b0;
    logic        fifo_peek_valid = 1'b0;
    logic        fifo_pop_ready;
    logic        fifo_pop_valid = 1'b0;
    logic [15:0] fifo_pop_gid = 16'h0;
    logic        out_valid;
    logic [15:0] out_gid;
    logic        out_ready = 1'b0;
    logic        idle;
    logic [31:0] groups_out;
    logic        spurious_err;
    logic        drop_err;

    group_fifo_drain #(.GID_WIDTH(16), .BUF_DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .drain_en       (drain_en),
        .fifo_peek_valid(fifo_peek_valid),
        .fifo_pop_ready (fifo_pop_ready),
        .fifo_pop_valid (fifo_pop_valid),
        .fifo_pop_gid   (fifo_pop_gid),
        .out_valid      (out_valid),
        .out_gid        (out_gid),
        .out_ready      (out_ready),
        .idle           (idle),
        .groups_out     (groups_out),
        .spurious_err   (spurious_err),
        .drop_err       (drop_err)
    );

    int n_pass  = 0;
    int n_total = 0;

    logic        rst_v = 1'b1;
    logic        drain_v = 1'b0;
    logic        ordy_v = 1'b0;
    logic        resp_pending = 1'b0;
    logic        hold_pending;
    logic [15:0] resp_gid = 16'h0;
    logic [15:0] up_q[$];
    logic [15:0] rx_q[$];
    int          pops = 0;

    typedef struct {
        logic        drain;
        logic        peek;
        logic        pv;
        logic [15:0] gid;
        logic        ordy;
        logic        e_pr;
        logic        e_ov;
        logic [15:0] e_gid;
        logic        e_idle;
        logic [31:0] e_groups;
    } vec_t;

    vec_t tbl[9];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // One cycle: drive at negedge, sample just after, model the upstream FIFO.
    task automatic tick();
        @(negedge clk);
        rst             = rst_v;
        drain_en        = drain_v;
        out_ready       = ordy_v;
        fifo_peek_valid = (up_q.size() != 0);
        fifo_pop_valid  = resp_pending;
        fifo_pop_gid    = resp_pending ? resp_gid : 16'h0;
        resp_pending    = 1'b0;
        #1;
        if (out_valid && out_ready) rx_q.push_back(out_gid);
        if (fifo_pop_ready) begin
            pops++;
            resp_gid     = (up_q.size() != 0) ? up_q.pop_front() : 16'hDEAD;
            resp_pending = 1'b1;
        end
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset();
        rst_v        = 1'b1;
        drain_v      = 1'b0;
        ordy_v       = 1'b0;
        resp_pending = 1'b0;
        up_q.delete();
        rx_q.delete();
        pops = 0;
        ticks(2);
        rst_v = 1'b0;
    endtask

    task automatic chk_rx(input string name, input logic [15:0] base,
                          input int n);
        chk({name, "_cnt"}, 64'(rx_q.size()), 64'(n));
        for (int i = 0; i < n && i < rx_q.size(); i++)
            chk($sformatf("%s_gid%0d", name, i), 64'(rx_q[i]),
                64'(base + 16'(i)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1'b0, 16'h00, 1'b1, 1'b0, 1'b0, 16'h00, 1'b1, 32'd0};
        tbl[1] = '{1'b1, 1'b1, 1'b0, 16'h00, 1'b1, 1'b1, 1'b0, 16'h00, 1'b0, 32'd0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 16'h10, 1'b1, 1'b1, 1'b0, 16'h00, 1'b0, 32'd0};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 16'h11, 1'b1, 1'b1, 1'b1, 16'h10, 1'b0, 32'd0};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 16'h12, 1'b1, 1'b0, 1'b1, 16'h11, 1'b0, 32'd1};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 16'h00, 1'b1, 1'b0, 1'b1, 16'h12, 1'b0, 32'd2};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 16'h00, 1'b1, 1'b0, 1'b0, 16'h00, 1'b0, 32'd3};
        tbl[7] = '{1'b0, 1'b0, 1'b0, 16'h00, 1'b1, 1'b0, 1'b0, 16'h00, 1'b0, 32'd3};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 16'h00, 1'b1, 1'b0, 1'b0, 16'h00, 1'b1, 32'd3};

        // reset state
        do_reset();
        tick();
        chk("rst_idle", 64'(idle), 64'd1);
        chk("rst_groups", 64'(groups_out), 64'd0);
        chk("rst_errs", 64'({spurious_err, drop_err}), 64'd0);
        chk("rst_outs", 64'({fifo_pop_ready, out_valid}), 64'd0);

        // three-gid drain, cycle by cycle
        do_reset();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            rst             = 1'b0;
            drain_en        = tbl[i].drain;
            fifo_peek_valid = tbl[i].peek;
            fifo_pop_valid  = tbl[i].pv;
            fifo_pop_gid    = tbl[i].gid;
            out_ready       = tbl[i].ordy;
            #1;
            chk($sformatf("vec%0d", i),
                64'({fifo_pop_ready, out_valid,
                     (out_valid ? out_gid : 16'h0), idle, groups_out}),
                64'({tbl[i].e_pr, tbl[i].e_ov, tbl[i].e_gid,
                     tbl[i].e_idle, tbl[i].e_groups}));
        end
        chk("vec_errs", 64'({spurious_err, drop_err}), 64'd0);

        // stalled downstream: credit stops pops at 4, then drain all 6
        do_reset();
        for (int i = 0; i < 6; i++) up_q.push_back(16'h20 + 16'(i));
        drain_v = 1'b1;
        ticks(10);
        chk("stall_pops", 64'(pops), 64'd4);
        chk("stall_ready", 64'(fifo_pop_ready), 64'd0);
        chk("stall_head", 64'({out_valid, out_gid}), 64'({1'b1, 16'h20}));
        ordy_v = 1'b1;
        ticks(15);
        chk_rx("stall_rx", 16'h20, 6);
        chk("stall_groups", 64'(groups_out), 64'd6);
        chk("stall_errs", 64'({spurious_err, drop_err}), 64'd0);

        // full buffer + handshake + same-cycle write keeps count at 4
        do_reset();
        for (int i = 0; i < 4; i++) up_q.push_back(16'h30 + 16'(i));
        drain_v = 1'b1;
        ticks(8);
        drain_v = 1'b0;
        ticks(3);
        ordy_v       = 1'b1;
        resp_pending = 1'b1;
        resp_gid     = 16'h34;
        tick();
        ordy_v  = 1'b0;
        drain_v = 1'b1;
        up_q.push_back(16'h35);
        ticks(5);
        chk("full_pops", 64'(pops), 64'd4);
        ordy_v = 1'b1;
        ticks(12);
        drain_v = 1'b0;
        ticks(3);
        chk_rx("full_rx", 16'h30, 6);
        chk("full_drop", 64'(drop_err), 64'd0);
        chk("full_spur", 64'(spurious_err), 64'd1);
        chk("full_idle", 64'(idle), 64'd1);

        // full buffer, no handshake: response discarded
        do_reset();
        for (int i = 0; i < 4; i++) up_q.push_back(16'h40 + 16'(i));
        drain_v = 1'b1;
        ticks(8);
        drain_v = 1'b0;
        ticks(3);
        resp_pending = 1'b1;
        resp_gid     = 16'h4F;
        ticks(2);
        chk("drop_err", 64'(drop_err), 64'd1);
        ordy_v = 1'b1;
        ticks(6);
        chk_rx("drop_rx", 16'h40, 4);
        chk("drop_empty", 64'(out_valid), 64'd0);

        // drain_en falls right after a pop is accepted
        do_reset();
        up_q.push_back(16'h50);
        up_q.push_back(16'h51);
        up_q.push_back(16'h52);
        drain_v = 1'b1;
        ordy_v  = 1'b1;
        ticks(2);
        drain_v = 1'b0;
        tick();
        tick();
        chk("stop_busy", 64'({idle, out_valid, out_gid}),
            64'({1'b0, 1'b1, 16'h50}));
        ticks(4);
        chk("stop_pops", 64'(pops), 64'd1);
        chk_rx("stop_rx", 16'h50, 1);
        chk("stop_idle", 64'(idle), 64'd1);
        chk("stop_spur", 64'(spurious_err), 64'd0);

        // response right after reset dropped mid-transfer is spurious
        do_reset();
        up_q.push_back(16'h60);
        drain_v = 1'b1;
        ticks(2);
        chk("mid_pops", 64'(pops), 64'd1);
        hold_pending = resp_pending;
        resp_pending = 1'b0;
        drain_v      = 1'b0;
        rst_v        = 1'b1;
        tick();
        rst_v        = 1'b0;
        resp_pending = hold_pending;
        ticks(2);
        chk("mid_spur", 64'(spurious_err), 64'd1);
        chk("mid_head", 64'({out_valid, out_gid}), 64'({1'b1, 16'h60}));

        // injected response with nothing in flight
        do_reset();
        ordy_v       = 1'b1;
        resp_pending = 1'b1;
        resp_gid     = 16'hAB;
        ticks(4);
        chk("inj_spur", 64'(spurious_err), 64'd1);
        chk_rx("inj_rx", 16'hAB, 1);
        chk("inj_groups", 64'(groups_out), 64'd1);
        ordy_v       = 1'b0;
        resp_pending = 1'b1;
        resp_gid     = 16'hCD;
        tick();
        drain_v = 1'b1;
        up_q.push_back(16'hEE);
        tick();
        rst_v = 1'b1;
        tick();
        chk("rst_gate", 64'({fifo_pop_ready, out_valid}), 64'd0);
        rst_v   = 1'b0;
        drain_v = 1'b0;
        up_q.delete();
        tick();
        chk("rst_clear", 64'({spurious_err, groups_out}), 64'd0);
        chk("rst_idle2", 64'({idle, out_valid}), 64'({1'b1, 1'b0}));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
